// File: rtl/esp_psram64h_qspi.sv
// Behavioural model of an ESP-PSRAM64H style serial/quad PSRAM slave with a small byte array.
// Inputs are sampled on the rising SCLK edge and outputs are launched on the falling edge.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | csn_i low, first command beat is being sampled
//   S_CMD    | remaining command bits/nibbles
//   S_ADDR   | 24-bit address, serial or quad
//   S_WAIT   | dummy cycles of the quad fast read
//   S_RDATA  | array or ID bytes are driven out
//   S_WDATA  | data bytes shifted in and written to the array
//   S_IGNORE | command done or unsupported, idle until csn_i rises
module esp_psram64h_qspi #(
   parameter logic [1:0]  CHIP_ID    = 2'd0,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       csn_i,
   input  logic [3:0] sio_i,
   output logic [3:0] sio_o,
   output logic [3:0] sio_oe_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
   } state_t;

   typedef enum logic [1:0] {OP_READ, OP_FREAD, OP_WRITE, OP_ID} op_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic                  cs_rst_n;
   state_t                state_q, state_d;
   op_t                   op_q, op_d;
   logic                  quad_q, quad_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [23:0]           sh_q, sh_d, sh_in;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            id_idx_q, id_idx_d;
   logic                  mode_q, mode_d;
   logic                  pend_vld_q, pend_vld_d;
   logic                  pend_qpi_q, pend_qpi_d;
   logic                  rsten_q, rsten_d;
   logic                  lanes4;
   logic [7:0]            cmd;
   logic                  mem_we;
   logic [7:0]            id_byte, rd_byte;
   logic [3:0]            sio_o_q, sio_o_d;
   logic [3:0]            sio_oe_q, sio_oe_d;
   logic [7:0]            mem_q [2**ADDR_WIDTH];

   // Deselect acts like a reset for everything transaction-scoped.
   assign cs_rst_n = rst_n_i & ~csn_i;

   always_comb begin
      lanes4 = (state_q == S_IDLE || state_q == S_CMD) ? mode_q : quad_q;
      if (lanes4) begin
         sh_in = (sh_q << 4) | {20'd0, sio_i};
      end else begin
         sh_in = (sh_q << 1) | {23'd0, sio_i[0]};
      end
      cmd = sh_in[7:0];
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      quad_d     = quad_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      addr_d     = addr_q;
      id_idx_d   = id_idx_q;
      pend_vld_d = pend_vld_q;
      pend_qpi_d = pend_qpi_q;
      rsten_d    = rsten_q;
      mem_we     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            sh_d       = sh_in;
            cnt_d      = mode_q ? 5'd0 : 5'd6;
            state_d    = S_CMD;
            pend_vld_d = 1'b0;
         end
         S_CMD: begin
            sh_d = sh_in;
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               state_d = S_IGNORE;
               quad_d  = mode_q;
               rsten_d = (cmd == 8'h66);
               if (cmd == 8'h99 && rsten_q) begin
                  pend_vld_d = 1'b1;
                  pend_qpi_d = 1'b0;
               end
               if (!mode_q) begin
                  case (cmd)
                     8'h03: begin state_d = S_ADDR; op_d = OP_READ;  quad_d = 1'b0; end
                     8'h02: begin state_d = S_ADDR; op_d = OP_WRITE; quad_d = 1'b0; end
                     8'hEB: begin state_d = S_ADDR; op_d = OP_FREAD; quad_d = 1'b1; end
                     8'h38: begin state_d = S_ADDR; op_d = OP_WRITE; quad_d = 1'b1; end
                     8'h9F: begin state_d = S_ADDR; op_d = OP_ID;    quad_d = 1'b0; end
                     8'h35: begin pend_vld_d = 1'b1; pend_qpi_d = 1'b1; end
                     default: ;
                  endcase
               end else begin
                  case (cmd)
                     8'h02, 8'h38: begin state_d = S_ADDR; op_d = OP_WRITE; end
                     8'hEB:        begin state_d = S_ADDR; op_d = OP_FREAD; end
                     8'hF5:        begin pend_vld_d = 1'b1; pend_qpi_d = 1'b0; end
                     default: ;
                  endcase
               end
               cnt_d = quad_d ? 5'd5 : 5'd23;
            end
         end
         S_ADDR: begin
            sh_d = sh_in;
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               addr_d   = sh_in[ADDR_WIDTH-1:0];
               id_idx_d = 2'd0;
               cnt_d    = quad_q ? 5'd1 : 5'd7;
               case (op_q)
                  OP_FREAD: begin state_d = S_WAIT; cnt_d = 5'd5; end
                  OP_WRITE: state_d = S_WDATA;
                  default:  state_d = S_RDATA;
               endcase
            end
         end
         S_WAIT: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               state_d = S_RDATA;
               cnt_d   = quad_q ? 5'd1 : 5'd7;
            end
         end
         S_RDATA: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               cnt_d  = quad_q ? 5'd1 : 5'd7;
               addr_d = addr_q + ADDR_ONE;
               if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
            end
         end
         S_WDATA: begin
            sh_d = sh_in;
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end else begin
               mem_we = 1'b1;
               cnt_d  = quad_q ? 5'd1 : 5'd7;
               addr_d = addr_q + ADDR_ONE;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      unique case (id_idx_q)
         2'd0:    id_byte = 8'h0D;
         2'd1:    id_byte = 8'h5D;
         2'd2:    id_byte = {6'b0, CHIP_ID};
         default: id_byte = 8'h00;
      endcase
      rd_byte = (op_q == OP_ID) ? id_byte : mem_q[addr_q];

      sio_o_d  = 4'h0;
      sio_oe_d = 4'h0;
      if (state_q == S_RDATA) begin
         if (quad_q) begin
            sio_oe_d = 4'hF;
            sio_o_d  = cnt_q[0] ? rd_byte[7:4] : rd_byte[3:0];
         end else begin
            sio_oe_d = 4'h2;
            sio_o_d  = {2'b00, rd_byte[cnt_q[2:0]], 1'b0};
         end
      end
   end

   assign mode_d = pend_vld_q ? pend_qpi_q : mode_q;

   always_ff @(posedge clk_i or negedge cs_rst_n) begin
      if (!cs_rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_READ;
         quad_q   <= 1'b0;
         cnt_q    <= 5'd0;
         sh_q     <= 24'd0;
         addr_q   <= '0;
         id_idx_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         quad_q   <= quad_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         addr_q   <= addr_d;
         id_idx_q <= id_idx_d;
      end
   end

   // Mode requests survive deselect so they can be committed on the csn_i rising edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_vld_q <= 1'b0;
         pend_qpi_q <= 1'b0;
         rsten_q    <= 1'b0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_qpi_q <= pend_qpi_d;
         rsten_q    <= rsten_d;
      end
   end

   always_ff @(posedge csn_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mode_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[addr_q] <= sh_in[7:0];
      end
   end

   always_ff @(negedge clk_i or negedge cs_rst_n) begin
      if (!cs_rst_n) begin
         sio_o_q  <= 4'h0;
         sio_oe_q <= 4'h0;
      end else begin
         sio_o_q  <= sio_o_d;
         sio_oe_q <= sio_oe_d;
      end
   end

   assign sio_o    = sio_o_q;
   assign sio_oe_o = sio_oe_q;

endmodule

// File: tb/tb_esp_psram64h_qspi.sv
// Scoreboard bench for esp_psram64h_qspi: a host model drives transactions and keeps a
// byte-array/mode reference; a monitor reassembles driven bytes and compares them.
module tb_esp_psram64h_qspi;

   localparam logic [1:0] TB_CHIP = 2'd2;
   localparam int         MEM     = 4096;

   typedef struct packed {
      logic [7:0] data;
      logic       quad;
      logic       chk;
   } exp_t;

   typedef enum {K_NONE, K_READ, K_FREAD, K_WRITE, K_ID} kind_t;

   logic       clk_i;
   logic       rst_n_i;
   logic       csn_i;
   logic [3:0] sio_i;
   logic [3:0] sio_o;
   logic [3:0] sio_oe_o;

   int         checks;
   int         errors;
   exp_t       sb_q[$];
   logic [7:0] wr_data[$];
   logic [7:0] ref_mem [MEM];
   bit         ref_ok  [MEM];
   bit         ref_qpi;
   bit         ref_rsten;

   esp_psram64h_qspi #(.CHIP_ID(TB_CHIP), .ADDR_WIDTH(12)) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .csn_i    (csn_i),
      .sio_i    (sio_i),
      .sio_o    (sio_o),
      .sio_oe_o (sio_oe_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp_v, $time);
      end
   endtask

   task automatic drive_cycle(input logic [3:0] v);
      @(negedge clk_i);
      #1;
      csn_i = 1'b0;
      sio_i = v;
   endtask

   task automatic send_bits(input logic [23:0] v, input int n, input bit quad);
      for (int i = n - 1; i >= 0; i--) begin
         if (quad) drive_cycle(v[4*i +: 4]);
         else      drive_cycle({3'b000, v[i]});
      end
   endtask

   // One chip-select framed transaction; expectations come from the reference state.
   task automatic txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes,
                      input int partial, input bit rst_abort);
      bit         qc;
      bit         q;
      kind_t      k;
      int         a;
      logic [7:0] d;
      exp_t       e;
      qc = ref_qpi;
      q  = qc;
      k  = K_NONE;
      if (!qc) begin
         case (cmd)
            8'h03: begin k = K_READ;  q = 1'b0; end
            8'h02: begin k = K_WRITE; q = 1'b0; end
            8'hEB: begin k = K_FREAD; q = 1'b1; end
            8'h38: begin k = K_WRITE; q = 1'b1; end
            8'h9F: begin k = K_ID;    q = 1'b0; end
            default: ;
         endcase
      end else begin
         case (cmd)
            8'h02, 8'h38: k = K_WRITE;
            8'hEB:        k = K_FREAD;
            default: ;
         endcase
      end
      send_bits({16'h0, cmd}, qc ? 2 : 8, qc);
      if (k != K_NONE) send_bits(addr, q ? 6 : 24, q);
      a = int'(addr[11:0]);
      case (k)
         K_WRITE: begin
            for (int b = 0; b < nbytes; b++) begin
               d = (wr_data.size() > 0) ? wr_data.pop_front() : 8'($urandom);
               send_bits({16'h0, d}, q ? 2 : 8, q);
               ref_mem[a] = d;
               ref_ok[a]  = 1'b1;
               a = (a + 1) % MEM;
            end
            if (partial > 0) send_bits(24'($urandom), partial, q);
         end
         K_READ, K_FREAD: begin
            for (int b = 0; b < nbytes; b++) begin
               e.data = ref_mem[a];
               e.quad = q;
               e.chk  = ref_ok[a];
               sb_q.push_back(e);
               a = (a + 1) % MEM;
            end
            if (k == K_FREAD) repeat (6) drive_cycle(4'h0);
            repeat (nbytes * (q ? 2 : 8)) drive_cycle(4'h0);
         end
         K_ID: begin
            for (int b = 0; b < nbytes; b++) begin
               e.data = (b == 0) ? 8'h0D : (b == 1) ? 8'h5D : (b == 2) ? {6'b0, TB_CHIP} : 8'h00;
               e.quad = 1'b0;
               e.chk  = 1'b1;
               sb_q.push_back(e);
            end
            repeat (nbytes * 8) drive_cycle(4'h0);
         end
         default: repeat (12) drive_cycle(4'($urandom));
      endcase
      if (rst_abort) begin
         @(negedge clk_i);
         #1;
         rst_n_i = 1'b0;
         sio_i   = 4'h0;
         @(negedge clk_i);
         #1;
         csn_i = 1'b1;
         #1;
         chk("abort_oe", {28'h0, sio_oe_o}, 32'h0);
         @(negedge clk_i);
         #1;
         rst_n_i   = 1'b1;
         ref_qpi   = 1'b0;
         ref_rsten = 1'b0;
      end else begin
         @(negedge clk_i);
         #1;
         csn_i = 1'b1;
         sio_i = 4'h0;
         #1;
         chk("csn_high_oe", {28'h0, sio_oe_o}, 32'h0);
         chk("csn_high_o", {28'h0, sio_o}, 32'h0);
         if (cmd == 8'h99 && ref_rsten) ref_qpi = 1'b0;
         if (!qc && cmd == 8'h35) ref_qpi = 1'b1;
         if (qc && cmd == 8'hF5) ref_qpi = 1'b0;
         ref_rsten = (cmd == 8'h66);
      end
      chk("sb_drain", sb_q.size(), 0);
      sb_q.delete();
      repeat (2) @(negedge clk_i);
   endtask

   // Monitor: sample at the rising edge, half a cycle after the DUT launched the data.
   initial begin : monitor
      logic [7:0] acc;
      int         nb;
      exp_t       e;
      acc = 8'h0;
      nb  = 0;
      forever begin
         @(posedge clk_i);
         if (csn_i || !rst_n_i) begin
            acc = 8'h0;
            nb  = 0;
         end else if (sio_oe_o != 4'h0) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_drive", {28'h0, sio_oe_o}, 32'h0);
            end else begin
               e = sb_q[0];
               chk("oe_lanes", {28'h0, sio_oe_o}, e.quad ? 32'hF : 32'h2);
               if (e.quad) begin
                  acc = {acc[3:0], sio_o};
                  nb += 4;
               end else begin
                  acc = {acc[6:0], sio_o[1]};
                  nb += 1;
               end
               if (nb >= 8) begin
                  void'(sb_q.pop_front());
                  nb = 0;
                  if (e.chk) chk("rd_byte", {24'h0, acc}, {24'h0, e.data});
               end
            end
         end else begin
            chk("idle_sio_o", {28'h0, sio_o}, 32'h0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  cmd;
      logic [11:0] lo;
      logic [23:0] addr;
      int          op;
      checks    = 0;
      errors    = 0;
      ref_qpi   = 1'b0;
      ref_rsten = 1'b0;
      rst_n_i   = 1'b0;
      csn_i     = 1'b1;
      sio_i     = 4'h0;
      repeat (3) @(negedge clk_i);
      chk("rst_oe", {28'h0, sio_oe_o}, 32'h0);
      chk("rst_o", {28'h0, sio_o}, 32'h0);
      #1;
      rst_n_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // Wrap-around write and readback in SPI.
      wr_data = '{8'h11, 8'h22};
      txn(8'h02, 24'h000FFF, 2, 0, 0);
      txn(8'h03, 24'h000FFF, 2, 0, 0);
      txn(8'h03, 24'h000000, 1, 0, 0);
      txn(8'h9F, 24'h000000, 4, 0, 0);
      txn(8'h38, 24'h000100, 3, 0, 0);
      txn(8'hEB, 24'h000100, 3, 0, 0);
      txn(8'hAB, 24'h000000, 0, 0, 0);

      // QPI write/fast-read, then an aborted write nibble.
      txn(8'h35, 24'h0, 0, 0, 0);
      wr_data = '{8'hA5, 8'h3C};
      txn(8'h38, 24'h000010, 2, 0, 0);
      txn(8'hEB, 24'h000010, 2, 0, 0);
      txn(8'h38, 24'h000010, 0, 1, 0);
      txn(8'hEB, 24'h000010, 2, 0, 0);

      // Leaving QPI by exit command, by reset-enable/reset, and a cancelled reset-enable.
      txn(8'hF5, 24'h0, 0, 0, 0);
      txn(8'h03, 24'h000FFF, 2, 0, 0);
      txn(8'h35, 24'h0, 0, 0, 0);
      txn(8'h66, 24'h0, 0, 0, 0);
      txn(8'h99, 24'h0, 0, 0, 0);
      txn(8'h03, 24'h000010, 2, 0, 0);
      txn(8'h35, 24'h0, 0, 0, 0);
      txn(8'h66, 24'h0, 0, 0, 0);
      txn(8'hEB, 24'h000010, 1, 0, 0);
      txn(8'h99, 24'h0, 0, 0, 0);
      txn(8'hEB, 24'h000010, 2, 0, 0);

      // Reset pulse in the middle of a QPI write.
      txn(8'h38, 24'h000020, 3, 0, 0);
      txn(8'h38, 24'h000020, 2, 1, 1);
      txn(8'h03, 24'h000020, 3, 0, 0);

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0:       lo = 12'hFFE;
            1:       lo = 12'h010;
            2:       lo = 12'h7FF;
            default: lo = 12'($urandom);
         endcase
         addr = {12'($urandom), lo};
         op   = $urandom_range(0, 5);
         case (op)
            0, 1: begin
               cmd = ($urandom_range(0, 1) != 0) ? 8'h38 : 8'h02;
               txn(cmd, addr, $urandom_range(1, 4), $urandom_range(0, 3), 0);
            end
            2, 3: begin
               cmd = (ref_qpi || $urandom_range(0, 1) != 0) ? 8'hEB : 8'h03;
               txn(cmd, addr, $urandom_range(1, 4), 0, 0);
            end
            4: begin
               cmd = ref_qpi ? 8'hF5 : (($urandom_range(0, 1) != 0) ? 8'h35 : 8'h9F);
               txn(cmd, addr, 3, 0, 0);
            end
            default: txn(8'($urandom), addr, 2, 0, 0);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
